// File: rtl/clk_gate_seq.sv
// Clock-gate sequencer: turns per-channel clock enables on/off one at a time,
// holding off further changes for a settle window and acknowledging when stable.
module clk_gate_seq #(
  parameter int                NUM_CH   = 4,
  parameter int                SETTLE   = 8,
  parameter logic [NUM_CH-1:0] AON_MASK = {NUM_CH{1'b0}}
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] ack,
  output logic              busy
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [IW-1:0]     cur_q, cur_n;
  logic [NUM_CH-1:0] ce_q, ce_n;
  logic [NUM_CH-1:0] ack_q, ack_n;
  logic              busy_q, busy_n;
  logic [NUM_CH-1:0] req_eff;
  logic [NUM_CH-1:0] diff;
  logic [IW-1:0]     k;

  assign req_eff = req | AON_MASK;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cur_n   = cur_q;
    ce_n    = ce_q;
    ack_n   = ack_q;
    busy_n  = busy_q;
    diff    = req_eff ^ ce_q;
    k       = '0;
    // Scan downward so the lowest differing channel wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (diff[i]) k = IW'(i);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (|diff) begin
          ce_n[k] = ~ce_q[k];
          if (ce_q[k]) ack_n[k] = 1'b0;
          cur_n   = k;
          cnt_n   = CW'(SETTLE);
          state_n = ST_SETTLE;
          busy_n  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else begin
          state_n       = ST_IDLE;
          busy_n        = 1'b0;
          ack_n[cur_q]  = ce_q[cur_q];
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      ce_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      cur_q   <= cur_n;
      ce_q    <= ce_n;
      ack_q   <= ack_n;
      busy_q  <= busy_n;
    end
  end

  assign ce   = ce_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_clk_gate_seq.sv
// Directed bench for clk_gate_seq (NUM_CH=4, SETTLE=3): one plain instance
// and one with channel 0 always-on.
module tb_clk_gate_seq;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ce, ack;
  logic       busy;
  logic [3:0] req_a;
  logic [3:0] ce_a, ack_a;
  logic       busy_a;

  int checks = 0;
  int errors = 0;

  clk_gate_seq #(
    .NUM_CH(4), .SETTLE(3), .AON_MASK(4'b0000)
  ) dut (
    .clkin(clk), .rst(rst), .req(req),
    .ce(ce), .ack(ack), .busy(busy)
  );

  clk_gate_seq #(
    .NUM_CH(4), .SETTLE(3), .AON_MASK(4'b0001)
  ) dut_a (
    .clkin(clk), .rst(rst), .req(req_a),
    .ce(ce_a), .ack(ack_a), .busy(busy_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] e_ce,
                      input logic [3:0] e_ack, input logic e_busy);
    chk({tag, ".ce"}, ce, e_ce);
    chk({tag, ".ack"}, ack, e_ack);
    chkb({tag, ".busy"}, busy, e_busy);
  endtask

  initial begin
    logic [3:0] e_ce, e_ack;
    logic       e_busy;
    rst   = 1'b1;
    req   = 4'b0000;
    req_a = 4'b0000;
    tick();
    tick();
    chk3("reset", 4'b0000, 4'b0000, 1'b0);
    chk("reset_a.ce", ce_a, 4'b0000);
    chkb("reset_a.busy", busy_a, 1'b0);

    // AON channel comes up by itself; plain instance stays idle
    rst = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk("aon.ce", ce_a, 4'b0001);
      chk("aon.ack", ack_a, (t >= 5) ? 4'b0001 : 4'b0000);
      chkb("aon.busy", busy_a, (t >= 1 && t <= 4));
      chk3("idle", 4'b0000, 4'b0000, 1'b0);
    end

    // All four requested at once: ascending order, 5 edges apart
    req = 4'b1111;
    for (int t = 1; t <= 20; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        e_ce[i]  = (t >= 1 + 5 * i);
        e_ack[i] = (t >= 5 + 5 * i);
      end
      e_busy = (t % 5) != 0;
      chk3("multi", e_ce, e_ack, e_busy);
    end

    // Bring to 0111, then turn off channel 1
    req = 4'b0111;
    tick();
    chk3("off3", 4'b0111, 4'b0111, 1'b1);
    for (int t = 2; t <= 5; t++) tick();
    chk3("off3.done", 4'b0111, 4'b0111, 1'b0);
    req = 4'b0101;
    tick();
    chk3("off1.e1", 4'b0101, 4'b0101, 1'b1);
    tick();
    tick();
    tick();
    chk3("off1.e4", 4'b0101, 4'b0101, 1'b1);
    tick();
    chk3("off1.e5", 4'b0101, 4'b0101, 1'b0);

    // Clear everything to set up the glitch case
    req = 4'b0000;
    for (int t = 1; t <= 10; t++) tick();
    chk3("clear", 4'b0000, 4'b0000, 1'b0);

    // Glitch on req[2] while channel 0 settles
    req = 4'b0001;
    tick();
    chk3("glitch.e1", 4'b0001, 4'b0000, 1'b1);
    req = 4'b0101;
    tick();
    tick();
    chk3("glitch.e3", 4'b0001, 4'b0000, 1'b1);
    req = 4'b0001;
    tick();
    tick();
    chk3("glitch.e5", 4'b0001, 4'b0001, 1'b0);
    for (int t = 6; t <= 9; t++) begin
      tick();
      chk3("glitch.after", 4'b0001, 4'b0001, 1'b0);
    end

    // Reset abort at cnt=1 during channel 1 rise
    req = 4'b0011;
    tick();
    chk3("abort.e1", 4'b0011, 4'b0001, 1'b1);
    tick();
    tick();
    chk3("abort.e3", 4'b0011, 4'b0001, 1'b1);
    rst = 1'b1;
    tick();
    chk3("abort.rst", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    chk3("restart.e1", 4'b0001, 4'b0000, 1'b1);
    for (int t = 2; t <= 5; t++) tick();
    chk3("restart.e5", 4'b0001, 4'b0001, 1'b0);
    tick();
    chk3("restart.e6", 4'b0011, 4'b0001, 1'b1);
    for (int t = 7; t <= 10; t++) tick();
    chk3("restart.e10", 4'b0011, 4'b0011, 1'b0);

    // Request for ch3 arrives mid-settle and is serviced afterwards
    req = 4'b0111;
    tick();
    chk3("persist.e1", 4'b0111, 4'b0011, 1'b1);
    tick();
    req = 4'b1111;
    tick();
    tick();
    chk3("persist.e4", 4'b0111, 4'b0011, 1'b1);
    tick();
    chk3("persist.e5", 4'b0111, 4'b0111, 1'b0);
    tick();
    chk3("persist.e6", 4'b1111, 4'b0111, 1'b1);
    for (int t = 7; t <= 10; t++) tick();
    chk3("persist.e10", 4'b1111, 4'b1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
